// File: rtl/bldc_pkg.sv
// Shared constants for the BLDC driver: hall commutation sequence and table,
// plus small decode helpers used by the core and the quadrature counter.
package bldc_pkg;

  localparam int NUM_HALL_STATES = 6;

  typedef logic [2:0] hall_t;
  typedef logic [1:0] phase_t;

  localparam phase_t PHASE_A = 2'd0;
  localparam phase_t PHASE_B = 2'd1;
  localparam phase_t PHASE_C = 2'd2;

  typedef struct packed {
    phase_t src;
    phase_t snk;
  } comm_t;

  localparam logic [2:0] HALL_IDX_NONE = 3'd7;

  // Index 0 is the LSB entry; forward rotation walks indices upward.
  localparam hall_t [NUM_HALL_STATES-1:0] HALL_SEQ = {
    3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
  };

  localparam comm_t [NUM_HALL_STATES-1:0] COMM_TABLE = {
    PHASE_C, PHASE_B,
    PHASE_C, PHASE_A,
    PHASE_B, PHASE_A,
    PHASE_B, PHASE_C,
    PHASE_A, PHASE_C,
    PHASE_A, PHASE_B
  };

  function automatic logic [2:0] hallIndex(input hall_t h);
    logic [2:0] idx;
    idx = HALL_IDX_NONE;
    for (int i = 0; i < NUM_HALL_STATES; i++) begin
      if (HALL_SEQ[i] == h) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] hallNextIdx(input logic [2:0] idx);
    return (idx == 3'(NUM_HALL_STATES - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [2:0] hallPrevIdx(input logic [2:0] idx);
    return (idx == 3'd0) ? 3'(NUM_HALL_STATES - 1) : idx - 3'd1;
  endfunction

  function automatic comm_t commLookup(input logic [2:0] idx);
    comm_t c;
    c = COMM_TABLE[0];
    for (int i = 0; i < NUM_HALL_STATES; i++) begin
      if (3'(i) == idx) c = COMM_TABLE[i];
    end
    return c;
  endfunction

  function automatic logic [2:0] phaseMask(input phase_t p);
    return 3'b001 << p;
  endfunction

  // Gray-coded A/B mapped onto a 0..3 rotation position.
  function automatic logic [1:0] quadPhase(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/bldc_quad_counter.sv
// x4 quadrature position counter on already-synchronized A/B inputs (bit 0 = A).
module bldc_quad_counter
  import bldc_pkg::*;
#(
  parameter int WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       quad_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [1:0]       quadPrev_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       phaseStep;

  // A position difference of 2 means both bits flipped at once; it is dropped.
  always_comb begin
    phaseStep = quadPhase(quad_i) - quadPhase(quadPrev_q);
    count_d   = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (phaseStep == 2'd1) begin
      count_d = count_q + WIDTH'(1);
    end else if (phaseStep == 2'd3) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quadPrev_q <= 2'b00;
      count_q    <= '0;
    end else begin
      quadPrev_q <= quad_i;
      count_q    <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bldc_driver_core.sv
// Six-step BLDC gate driver: soft-start PWM, hall commutation with dead time,
// hall fault latching, and hall/encoder position counters.
module bldc_driver_core
  import bldc_pkg::*;
#(
  parameter int PHASE_DRIVER_MAX_COUNTER = 'h3FE,
  parameter int MAX_DUTY_CYCLE           = 'h3FE,
  parameter int DUTY_CYCLE_STEP_RES      = 1,
  parameter int DEAD_TIME                = 8,
  parameter int ENCODER_COUNT_WIDTH      = 15,
  parameter int HALL_COUNT_WIDTH         = 7,
  localparam int DUTY_W = $clog2(MAX_DUTY_CYCLE + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic [DUTY_W-1:0]              duty_cycle,
  input  logic [2:0]                     hall,
  input  logic [1:0]                     enc,
  input  logic                           reset_enc_count,
  input  logic                           reset_hall_count,
  output logic [2:0]                     phaseH,
  output logic [2:0]                     phaseL,
  output logic [ENCODER_COUNT_WIDTH-1:0] enc_count,
  output logic [HALL_COUNT_WIDTH-1:0]    hall_count,
  output logic                           connected,
  output logic                           fault
);

  localparam int CNT_W     = (PHASE_DRIVER_MAX_COUNTER > 0) ? $clog2(PHASE_DRIVER_MAX_COUNTER + 1) : 1;
  localparam int DT_W      = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
  localparam int DEAD_LOAD = (DEAD_TIME > 0) ? DEAD_TIME - 1 : 0;
  localparam logic [DUTY_W-1:0] DUTY_LIMIT = DUTY_W'(MAX_DUTY_CYCLE);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PHASE_DRIVER_MAX_COUNTER);

  hall_t      hallMeta_q, hall_q, hallPrev_q;
  logic [1:0] encMeta_q, enc_q;

  logic [CNT_W-1:0]            pwmCnt_q, pwmCnt_d;
  logic [DUTY_W-1:0]           dutyApplied_q, dutyApplied_d;
  logic [DT_W-1:0]             deadCnt_q, deadCnt_d;
  logic                        fault_q, fault_d;
  logic [HALL_COUNT_WIDTH-1:0] hallCount_q, hallCount_d;

  logic              pwmWrap, pwmOn;
  logic [DUTY_W-1:0] dutyTarget;
  logic [2:0]        hallIdxCur, hallIdxPrev;
  logic              hallChanged, bothValid, stepFwd, stepRev, illegalStep;
  logic              blank, driveAllowed;
  comm_t             comm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hallMeta_q <= 3'b111;
      hall_q     <= 3'b111;
      encMeta_q  <= 2'b00;
      enc_q      <= 2'b00;
    end else begin
      hallMeta_q <= hall;
      hall_q     <= hallMeta_q;
      encMeta_q  <= enc;
      enc_q      <= encMeta_q;
    end
  end

  // Soft start: duty climbs by one step per PWM period but falls to a lower
  // command in a single period, and is forced to zero whenever the drive is off.
  always_comb begin
    pwmWrap       = (pwmCnt_q == CNT_LAST);
    pwmCnt_d      = pwmWrap ? '0 : pwmCnt_q + CNT_W'(1);
    dutyTarget    = (duty_cycle > DUTY_LIMIT) ? DUTY_LIMIT : duty_cycle;
    dutyApplied_d = dutyApplied_q;
    if (!en) begin
      dutyApplied_d = '0;
    end else if (pwmWrap) begin
      if (dutyTarget <= dutyApplied_q) begin
        dutyApplied_d = dutyTarget;
      end else if (32'(dutyTarget - dutyApplied_q) > 32'(DUTY_CYCLE_STEP_RES)) begin
        dutyApplied_d = dutyApplied_q + DUTY_W'(DUTY_CYCLE_STEP_RES);
      end else begin
        dutyApplied_d = dutyTarget;
      end
    end
  end

  assign pwmOn = 32'(pwmCnt_q) < 32'(dutyApplied_q);

  always_comb begin
    hallIdxCur  = hallIndex(hall_q);
    hallIdxPrev = hallIndex(hallPrev_q);
    hallChanged = (hall_q != hallPrev_q);
    bothValid   = (hallIdxCur != HALL_IDX_NONE) && (hallIdxPrev != HALL_IDX_NONE);
    stepFwd     = hallChanged && bothValid && (hallIdxCur == hallNextIdx(hallIdxPrev));
    stepRev     = hallChanged && bothValid && (hallIdxCur == hallPrevIdx(hallIdxPrev));
    illegalStep = hallChanged && bothValid && !stepFwd && !stepRev;
  end

  // Dead time starts in the very cycle the change is seen, so the loaded
  // value is one short of the full blanking length.
  always_comb begin
    deadCnt_d = deadCnt_q;
    if (hallChanged) begin
      deadCnt_d = DT_W'(DEAD_LOAD);
    end else if (deadCnt_q != '0) begin
      deadCnt_d = deadCnt_q - DT_W'(1);
    end
  end

  always_comb begin
    fault_d = fault_q;
    if (!en) begin
      fault_d = 1'b0;
    end else if ((hall_q == 3'b000) || illegalStep) begin
      fault_d = 1'b1;
    end
  end

  always_comb begin
    hallCount_d = hallCount_q;
    if (reset_hall_count) begin
      hallCount_d = '0;
    end else if (stepFwd) begin
      hallCount_d = hallCount_q + HALL_COUNT_WIDTH'(1);
    end else if (stepRev) begin
      hallCount_d = hallCount_q - HALL_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hallPrev_q    <= 3'b111;
      pwmCnt_q      <= '0;
      dutyApplied_q <= '0;
      deadCnt_q     <= '0;
      fault_q       <= 1'b0;
      hallCount_q   <= '0;
    end else begin
      hallPrev_q    <= hall_q;
      pwmCnt_q      <= pwmCnt_d;
      dutyApplied_q <= dutyApplied_d;
      deadCnt_q     <= deadCnt_d;
      fault_q       <= fault_d;
      hallCount_q   <= hallCount_d;
    end
  end

  // Source and sink are always distinct phases, so high and low sides of one
  // leg can never be enabled together.
  always_comb begin
    comm         = commLookup(hallIdxCur);
    blank        = (DEAD_TIME > 0) && (hallChanged || (deadCnt_q != '0));
    driveAllowed = en && !fault_q && connected && !blank && (hallIdxCur != HALL_IDX_NONE);
    phaseH       = 3'b000;
    phaseL       = 3'b000;
    if (driveAllowed) begin
      phaseL = phaseMask(comm.snk);
      if (pwmOn) phaseH = phaseMask(comm.src);
    end
  end

  assign connected  = (hall_q != 3'b111);
  assign fault      = fault_q;
  assign hall_count = hallCount_q;

  bldc_quad_counter #(
    .WIDTH(ENCODER_COUNT_WIDTH)
  ) u_quad_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .quad_i (enc_q),
    .clear_i(reset_enc_count),
    .count_o(enc_count)
  );

endmodule

// File: tb/tb_bldc_driver_core.sv
// Self-checking bench for bldc_driver_core: table-driven hall and encoder
// vectors plus hand sequences for ramp, faults, clears and async reset.
module tb_bldc_driver_core;

  localparam int MAXC   = 'h3FE;
  localparam int PERIOD = MAXC + 1;
  localparam int STEP   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [9:0]  duty_cycle = '0;
  logic [2:0]  hall = 3'b111;
  logic [1:0]  enc = 2'b00;
  logic        reset_enc_count = 1'b0;
  logic        reset_hall_count = 1'b0;
  logic [2:0]  phaseH, phaseL;
  logic [14:0] enc_count;
  logic [6:0]  hall_count;
  logic        connected, fault;

  always #5 clk = ~clk;

  bldc_driver_core #(
    .PHASE_DRIVER_MAX_COUNTER(MAXC),
    .MAX_DUTY_CYCLE          ('h3FE),
    .DUTY_CYCLE_STEP_RES     (STEP),
    .DEAD_TIME               (8),
    .ENCODER_COUNT_WIDTH     (15),
    .HALL_COUNT_WIDTH        (7)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .duty_cycle      (duty_cycle),
    .hall            (hall),
    .enc             (enc),
    .reset_enc_count (reset_enc_count),
    .reset_hall_count(reset_hall_count),
    .phaseH          (phaseH),
    .phaseL          (phaseL),
    .enc_count       (enc_count),
    .hall_count      (hall_count),
    .connected       (connected),
    .fault           (fault)
  );

  typedef struct {
    string name;
    int    exp;
  } sbEntry_t;

  typedef struct {
    logic [2:0] hallIn;
    logic [2:0] expH;
    logic [2:0] expL;
    int         delta;
  } hallVec_t;

  typedef struct {
    logic [1:0]  encIn;
    logic [14:0] expCount;
  } encVec_t;

  sbEntry_t sbQ[$];
  hallVec_t hallVecs[8];
  encVec_t  encVecs[11];
  int nChecks = 0;
  int nFails  = 0;
  int hallModel = 0;

  task automatic pushExp(input string name, input int exp);
    sbEntry_t e;
    e.name = name;
    e.exp  = exp;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input int actual);
    sbEntry_t e;
    nChecks++;
    if (sbQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_empty: got %0d with no expected entry", actual);
    end else begin
      e = sbQ.pop_front();
      if (actual != e.exp) begin
        nFails++;
        $display("[TB] FAIL %s: got %0d expected %0d", e.name, actual, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic enIn, input logic [9:0] dutyIn,
                               input logic [2:0] hallIn, input logic [1:0] encIn);
    en         = enIn;
    duty_cycle = dutyIn;
    hall       = hallIn;
    enc        = encIn;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measureWindow(input logic [2:0] srcMask, output int highCnt,
                               output logic [2:0] seenH, output logic overlap);
    highCnt = 0;
    seenH   = 3'b000;
    overlap = 1'b0;
    repeat (PERIOD) begin
      @(negedge clk);
      if ((phaseH & srcMask) != 3'b000) highCnt++;
      seenH   = seenH | phaseH;
      overlap = overlap | (|(phaseH & phaseL));
    end
  endtask

  initial begin
    int          highCnt;
    logic [2:0]  seenH;
    logic        overlap;

    hallVecs[0] = '{3'b100, 3'b001, 3'b100,  1};
    hallVecs[1] = '{3'b110, 3'b010, 3'b100,  1};
    hallVecs[2] = '{3'b010, 3'b010, 3'b001,  1};
    hallVecs[3] = '{3'b011, 3'b100, 3'b001,  1};
    hallVecs[4] = '{3'b001, 3'b100, 3'b010,  1};
    hallVecs[5] = '{3'b101, 3'b001, 3'b010,  1};
    hallVecs[6] = '{3'b100, 3'b001, 3'b100,  1};
    hallVecs[7] = '{3'b101, 3'b001, 3'b010, -1};

    encVecs[0]  = '{2'b01, 15'd1};
    encVecs[1]  = '{2'b11, 15'd2};
    encVecs[2]  = '{2'b10, 15'd3};
    encVecs[3]  = '{2'b00, 15'd4};
    encVecs[4]  = '{2'b10, 15'd3};
    encVecs[5]  = '{2'b11, 15'd2};
    encVecs[6]  = '{2'b01, 15'd1};
    encVecs[7]  = '{2'b00, 15'd0};
    encVecs[8]  = '{2'b11, 15'd0};
    encVecs[9]  = '{2'b00, 15'd0};
    encVecs[10] = '{2'b10, 15'h7FFF};

    // Reset values while rst_n is held low.
    waitCycles(3);
    pushExp("rst_phaseH", 0);
    pushExp("rst_phaseL", 0);
    pushExp("rst_enc_count", 0);
    pushExp("rst_hall_count", 0);
    pushExp("rst_fault", 0);
    pushExp("rst_connected", 0);
    checkOutput(int'(phaseH));
    checkOutput(int'(phaseL));
    checkOutput(int'(enc_count));
    checkOutput(int'(hall_count));
    checkOutput(int'(fault));
    checkOutput(int'(connected));

    // Soft start toward duty 200 on hall 101.
    rst_n = 1'b1;
    applyStimulus(1'b1, 10'd200, 3'b101, 2'b00);
    pushExp("start_connected", 1);
    pushExp("start_fault", 0);
    pushExp("start_phaseL", 3'b010);
    pushExp("start_hall_count", 0);
    pushExp("start_high_cycles", 200);
    pushExp("start_seenH", 3'b001);
    pushExp("start_overlap", 0);
    waitCycles(6 * PERIOD);
    checkOutput(int'(connected));
    checkOutput(int'(fault));
    checkOutput(int'(phaseL));
    checkOutput(int'(hall_count));
    measureWindow(3'b001, highCnt, seenH, overlap);
    checkOutput(highCnt);
    checkOutput(int'(seenH));
    checkOutput(int'(overlap));

    // Commutation table with dead time and hall counting.
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b1, 10'd200, hallVecs[r].hallIn, 2'b00);
      hallModel = (hallModel + hallVecs[r].delta) & 'h7F;
      pushExp($sformatf("dead_first_%0d", r), 0);
      pushExp($sformatf("dead_last_%0d", r), 0);
      pushExp($sformatf("phaseL_%0d", r), int'(hallVecs[r].expL));
      pushExp($sformatf("hall_count_%0d", r), hallModel);
      pushExp($sformatf("high_cycles_%0d", r), 200);
      pushExp($sformatf("seenH_%0d", r), int'(hallVecs[r].expH));
      pushExp($sformatf("overlap_%0d", r), 0);
      waitCycles(2);
      checkOutput(int'(phaseH | phaseL));
      waitCycles(7);
      checkOutput(int'(phaseH | phaseL));
      waitCycles(1);
      checkOutput(int'(phaseL));
      checkOutput(int'(hall_count));
      measureWindow(hallVecs[r].expH, highCnt, seenH, overlap);
      checkOutput(highCnt);
      checkOutput(int'(seenH));
      checkOutput(int'(overlap));
    end

    // Non-adjacent jump 101 -> 010 latches a fault until en drops.
    applyStimulus(1'b1, 10'd200, 3'b010, 2'b00);
    pushExp("illegal_blank", 0);
    pushExp("illegal_fault", 1);
    pushExp("illegal_hall_count", hallModel);
    pushExp("fault_gates_off", 0);
    pushExp("fault_cleared", 0);
    pushExp("post_fault_phaseL", 3'b001);
    waitCycles(2);
    checkOutput(int'(phaseH | phaseL));
    waitCycles(1);
    checkOutput(int'(fault));
    checkOutput(int'(hall_count));
    waitCycles(12);
    checkOutput(int'(phaseH | phaseL));
    en = 1'b0;
    waitCycles(1);
    checkOutput(int'(fault));
    en = 1'b1;
    waitCycles(1);
    checkOutput(int'(phaseL));

    // Open sensors, then all-zero hall fault.
    applyStimulus(1'b1, 10'd200, 3'b111, 2'b00);
    pushExp("open_connected", 0);
    pushExp("open_gates", 0);
    pushExp("open_fault", 0);
    waitCycles(2);
    checkOutput(int'(connected));
    checkOutput(int'(phaseH | phaseL));
    checkOutput(int'(fault));
    applyStimulus(1'b1, 10'd200, 3'b000, 2'b00);
    pushExp("zero_fault", 1);
    pushExp("zero_connected", 1);
    pushExp("zero_gates", 0);
    waitCycles(3);
    checkOutput(int'(fault));
    checkOutput(int'(connected));
    checkOutput(int'(phaseH | phaseL));
    applyStimulus(1'b1, 10'd200, 3'b101, 2'b00);
    pushExp("zero_fault_cleared", 0);
    pushExp("invalid_hall_count", hallModel);
    waitCycles(3);
    en = 1'b0;
    waitCycles(1);
    checkOutput(int'(fault));
    en = 1'b1;
    checkOutput(int'(hall_count));

    // Duty clamp at MAX_DUTY_CYCLE, then immediate drop to a lower command.
    duty_cycle = 10'd1023;
    pushExp("clamp_high_cycles", 1022);
    waitCycles(18 * PERIOD);
    measureWindow(3'b001, highCnt, seenH, overlap);
    checkOutput(highCnt);
    duty_cycle = 10'd50;
    pushExp("drop_high_cycles", 50);
    waitCycles(2 * PERIOD + 2);
    measureWindow(3'b001, highCnt, seenH, overlap);
    checkOutput(highCnt);

    // Quadrature vectors, including a double-bit change and underflow wrap.
    for (int r = 0; r < 11; r++) begin
      enc = encVecs[r].encIn;
      pushExp($sformatf("enc_count_%0d", r), int'(encVecs[r].expCount));
      waitCycles(3);
      checkOutput(int'(enc_count));
    end

    // Clear wins over a simultaneous decrement.
    enc = 2'b11;
    pushExp("enc_clear_priority", 0);
    pushExp("enc_clear_hold", 0);
    waitCycles(2);
    reset_enc_count = 1'b1;
    waitCycles(1);
    checkOutput(int'(enc_count));
    reset_enc_count = 1'b0;
    waitCycles(1);
    checkOutput(int'(enc_count));

    reset_hall_count = 1'b1;
    pushExp("hall_clear", 0);
    waitCycles(1);
    checkOutput(int'(hall_count));
    reset_hall_count = 1'b0;

    // Build up nonzero state, then assert rst_n in the middle of a clock high phase.
    enc = 2'b01;
    hall = 3'b100;
    pushExp("pre_reset_enc", 'h7FFF);
    pushExp("pre_reset_hall_count", 1);
    pushExp("pre_reset_phaseL", 3'b100);
    waitCycles(12);
    checkOutput(int'(enc_count));
    checkOutput(int'(hall_count));
    checkOutput(int'(phaseL));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    pushExp("async_phaseH", 0);
    pushExp("async_phaseL", 0);
    pushExp("async_enc_count", 0);
    pushExp("async_hall_count", 0);
    pushExp("async_fault", 0);
    pushExp("async_connected", 0);
    checkOutput(int'(phaseH));
    checkOutput(int'(phaseL));
    checkOutput(int'(enc_count));
    checkOutput(int'(hall_count));
    checkOutput(int'(fault));
    checkOutput(int'(connected));

    if (sbQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sbQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
